// File: rtl/exc_ctrl_if.sv
// Core-side bundle of the exception controller: request lines, mask and pending
// control, decoder status in, IRQ request and EPC/cause out.
interface exc_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int IDW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
  logic [N_IRQ-1:0] irq_src;
  logic [N_IRQ-1:0] pend_clr;
  logic             mask_wr;
  logic [N_IRQ-1:0] mask_din;
  logic             kernel;
  logic             hold;
  logic             undef;
  logic             eret;
  logic [31:0]      pc;
  logic             irq_req;
  logic [31:0]      epc;
  logic [IDW+1:0]   cause;
  logic [N_IRQ-1:0] pending;
  logic             in_service;

  modport master (
    output irq_src, pend_clr, mask_wr, mask_din, kernel, hold, undef, eret, pc,
    input  irq_req, epc, cause, pending, in_service
  );

  modport slave (
    input  irq_src, pend_clr, mask_wr, mask_din, kernel, hold, undef, eret, pc,
    output irq_req, epc, cause, pending, in_service
  );
endinterface

// File: rtl/exc_ctrl.sv
// Interrupt/exception controller: edge-latched pending, mask, fixed or round-robin
// arbitration, EPC/cause capture on kernel entry and in-service tracking until eret.
module exc_ctrl #(
  parameter int N_IRQ   = 4,
  parameter int RR_MODE = 0
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);
  localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t           state_q;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] pend_d;
  logic [N_IRQ-1:0] mask_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [31:0]      epc_q;
  logic [IDW+1:0]   cause_q;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] grant_onehot;
  logic [IDW-1:0]   chan;
  logic             irq_req;
  logic             take_irq;
  logic             take_undef;

  assign rise     = bus.irq_src & ~prev_q;
  assign eligible = pend_q & mask_q;
  // Built from registers only so the decoder sees no loop through pc/undef/eret.
  assign irq_req  = (state_q == IDLE) & (|eligible);
  assign take_irq = irq_req & ~bus.kernel & ~bus.hold;
  assign take_undef = bus.undef & ~bus.kernel & ~bus.hold & (state_q == IDLE) & ~take_irq;

  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    int             sum;
    chan  = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    if (RR_MODE == 0) begin
      for (int i = N_IRQ - 1; i >= 0; i--) begin
        if (eligible[i]) chan = IDW'(i);
      end
    end else begin
      // Scan upward starting just past the last granted channel.
      for (int k = 1; k <= N_IRQ; k++) begin
        sum = int'(rr_ptr_q) + k;
        idx = IDW'(sum % N_IRQ);
        if (!found && eligible[idx]) begin
          chan  = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign grant_onehot = take_irq ? (N_IRQ'(1) << chan) : '0;
  assign pend_d       = (pend_q & ~bus.pend_clr & ~grant_onehot) | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      rr_ptr_q <= IDW'(N_IRQ - 1);
      epc_q    <= '0;
      cause_q  <= '0;
    end else begin
      prev_q <= bus.irq_src;
      pend_q <= pend_d;
      if (bus.mask_wr) mask_q <= bus.mask_din;
      case (state_q)
        IDLE: begin
          if (take_irq) begin
            state_q  <= SERVICE;
            epc_q    <= bus.pc;
            cause_q  <= {2'b01, chan};
            rr_ptr_q <= chan;
          end else if (take_undef) begin
            // The faulting instruction is skipped on return.
            state_q <= SERVICE;
            epc_q   <= bus.pc + 32'd4;
            cause_q <= {2'b10, {IDW{1'b0}}};
          end
        end
        SERVICE: begin
          if (bus.eret) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.irq_req    = irq_req;
  assign bus.epc        = epc_q;
  assign bus.cause      = cause_q;
  assign bus.pending    = pend_q;
  assign bus.in_service = (state_q == SERVICE);
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: fixed-priority vector table plus a round-robin sequence.
module tb_exc_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  exc_ctrl_if #(.N_IRQ(4)) if_f ();
  exc_ctrl_if #(.N_IRQ(4)) if_r ();

  exc_ctrl #(.N_IRQ(4), .RR_MODE(0)) u_fix (.clk(clk), .reset(rst), .bus(if_f.slave));
  exc_ctrl #(.N_IRQ(4), .RR_MODE(1)) u_rr  (.clk(clk), .reset(rst), .bus(if_r.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  src;
    logic [3:0]  clr;
    logic        mwr;
    logic [3:0]  mdin;
    logic        kern;
    logic        hold;
    logic        undef;
    logic        eret;
    logic [31:0] pc;
    logic        req;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic [3:0]  pend;
    logic        insvc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [3:0] s, logic [3:0] c, logic mw, logic [3:0] md,
                              logic k, logic h, logic u, logic e, logic [31:0] p,
                              logic rq, logic [31:0] ep, logic [3:0] ca, logic [3:0] pd,
                              logic is);
    vec_t v;
    v.rst = r; v.src = s; v.clr = c; v.mwr = mw; v.mdin = md;
    v.kern = k; v.hold = h; v.undef = u; v.eret = e; v.pc = p;
    v.req = rq; v.epc = ep; v.cause = ca; v.pend = pd; v.insvc = is;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rr_cycle(input logic [3:0] src, input logic kern, input logic er);
    @(negedge clk);
    if_r.irq_src = src;
    if_r.kernel  = kern;
    if_r.eret    = er;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    if_f.irq_src = '0; if_f.pend_clr = '0; if_f.mask_wr = 1'b0; if_f.mask_din = '0;
    if_f.kernel = 1'b0; if_f.hold = 1'b0; if_f.undef = 1'b0; if_f.eret = 1'b0; if_f.pc = '0;
    if_r.irq_src = '0; if_r.pend_clr = '0; if_r.mask_wr = 1'b0; if_r.mask_din = '0;
    if_r.kernel = 1'b0; if_r.hold = 1'b0; if_r.undef = 1'b0; if_r.eret = 1'b0; if_r.pc = '0;

    //           rst src  clr  mw mdin k h u e pc            req epc           cause pend is
    tv.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h40,       0, 32'h0,   4'h0, 4'h0, 0)); // v0
    tv.push_back(mk(0, 4'h0, 4'h0, 1, 4'hF, 1, 0, 0, 0, 32'h40,       0, 32'h0,   4'h0, 4'h0, 0));
    tv.push_back(mk(0, 4'h4, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h40,       1, 32'h0,   4'h0, 4'h4, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h40,       0, 32'h40,  4'h6, 4'h0, 1));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h44,       0, 32'h40,  4'h6, 4'h0, 0));
    tv.push_back(mk(0, 4'hA, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h48,       1, 32'h40,  4'h6, 4'hA, 0)); // v5
    tv.push_back(mk(0, 4'hA, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h100,      0, 32'h100, 4'h5, 4'h8, 1));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h104,      1, 32'h100, 4'h5, 4'h8, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h200,      0, 32'h200, 4'h7, 4'h0, 1));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h204,      0, 32'h200, 4'h7, 4'h0, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 32'hFFFFFFFC, 0, 32'h0,   4'h8, 4'h0, 1)); // v10
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h80000000, 0, 32'h0,   4'h8, 4'h0, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 1, 0, 32'h300,      0, 32'h0,   4'h8, 4'h0, 0));
    tv.push_back(mk(0, 4'h1, 4'h0, 0, 4'h0, 1, 0, 0, 0, 32'h400,      1, 32'h0,   4'h8, 4'h1, 0));
    tv.push_back(mk(0, 4'h1, 4'h0, 0, 4'h0, 1, 0, 0, 0, 32'h400,      1, 32'h0,   4'h8, 4'h1, 0));
    tv.push_back(mk(0, 4'h1, 4'h0, 0, 4'h0, 0, 1, 0, 0, 32'h400,      1, 32'h0,   4'h8, 4'h1, 0)); // v15
    tv.push_back(mk(0, 4'h1, 4'h0, 0, 4'h0, 1, 0, 0, 0, 32'h400,      1, 32'h0,   4'h8, 4'h1, 0));
    tv.push_back(mk(0, 4'h1, 4'h0, 0, 4'h0, 0, 0, 1, 0, 32'h500,      0, 32'h500, 4'h4, 4'h0, 1));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h504,      0, 32'h500, 4'h4, 4'h0, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 32'h508,      0, 32'h500, 4'h4, 4'h0, 0));
    tv.push_back(mk(0, 4'h1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h50C,      0, 32'h500, 4'h4, 4'h1, 0)); // v20
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h510,      0, 32'h500, 4'h4, 4'h1, 0));
    tv.push_back(mk(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 0, 0, 32'h514,      0, 32'h500, 4'h4, 4'h1, 0));
    tv.push_back(mk(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 0, 0, 32'h518,      0, 32'h500, 4'h4, 4'h0, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 1, 4'hF, 0, 0, 0, 0, 32'h51C,      0, 32'h500, 4'h4, 4'h0, 0));
    tv.push_back(mk(0, 4'h2, 4'h0, 0, 4'h0, 1, 0, 0, 0, 32'h520,      1, 32'h500, 4'h4, 4'h2, 0)); // v25
    tv.push_back(mk(0, 4'h2, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h600,      0, 32'h600, 4'h5, 4'h0, 1));
    tv.push_back(mk(0, 4'h4, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h604,      1, 32'h600, 4'h5, 4'h4, 0));
    tv.push_back(mk(0, 4'h4, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h700,      0, 32'h700, 4'h6, 4'h0, 1));
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h704,      0, 32'h700, 4'h6, 4'h0, 1));
    tv.push_back(mk(0, 4'h4, 4'h0, 0, 4'h0, 0, 0, 1, 0, 32'h800,      0, 32'h700, 4'h6, 4'h4, 1)); // v30
    tv.push_back(mk(1, 4'h4, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h800,      0, 32'h0,   4'h0, 4'h0, 0));
    tv.push_back(mk(0, 4'h4, 4'h0, 0, 4'h0, 0, 0, 0, 0, 32'h800,      0, 32'h0,   4'h0, 4'h4, 0));
    tv.push_back(mk(0, 4'h4, 4'h0, 1, 4'hF, 1, 0, 0, 0, 32'h800,      1, 32'h0,   4'h0, 4'h4, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst           = tv[i].rst;
      if_f.irq_src  = tv[i].src;
      if_f.pend_clr = tv[i].clr;
      if_f.mask_wr  = tv[i].mwr;
      if_f.mask_din = tv[i].mdin;
      if_f.kernel   = tv[i].kern;
      if_f.hold     = tv[i].hold;
      if_f.undef    = tv[i].undef;
      if_f.eret     = tv[i].eret;
      if_f.pc       = tv[i].pc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d irq_req", i),    32'(if_f.irq_req),    32'(tv[i].req));
      chk($sformatf("v%0d epc", i),        if_f.epc,             tv[i].epc);
      chk($sformatf("v%0d cause", i),      32'(if_f.cause),      32'(tv[i].cause));
      chk($sformatf("v%0d pending", i),    32'(if_f.pending),    32'(tv[i].pend));
      chk($sformatf("v%0d in_service", i), 32'(if_f.in_service), 32'(tv[i].insvc));
    end

    // Round-robin: two channels re-raised every round must alternate 0,1,0,1.
    @(negedge clk);
    rst = 1'b1;
    if_f.irq_src = '0; if_f.mask_wr = 1'b0; if_f.kernel = 1'b1; if_f.undef = 1'b0; if_f.eret = 1'b0;
    @(posedge clk);
    #1;
    chk("rr reset rdy", 32'(if_r.irq_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if_r.mask_wr  = 1'b1;
    if_r.mask_din = 4'hF;
    if_r.kernel   = 1'b1;
    if_r.pc       = 32'h1000;
    @(posedge clk);
    #1;
    @(negedge clk);
    if_r.mask_wr = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rr_cycle(4'h3, 1'b1, 1'b0);
      chk($sformatf("rr%0d pend", r), 32'(if_r.pending), 32'd3);
      rr_cycle(4'h3, 1'b0, 1'b0);
      chk($sformatf("rr%0d cause", r), 32'(if_r.cause), 32'({2'b01, 2'(r % 2)}));
      chk($sformatf("rr%0d insvc", r), 32'(if_r.in_service), 32'd1);
      rr_cycle(4'h0, 1'b1, 1'b1);
      chk($sformatf("rr%0d idle", r), 32'(if_r.in_service), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
